// File: rtl/router_pkg.sv
// Shared constants and header-field helper for the router packet FIFOs.
package router_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_LEN_LSB    = 2;
    localparam int HDR_MAX_W      = 64;

    // Length field sits in the upper header bits; callers size-cast to their own width.
    function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr,
                                                     input int unsigned         lsb);
        return hdr >> lsb;
    endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Simple dual-port storage array: synchronous write, combinational read.
module router_fifo_ram
    import router_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wr_ptr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_ptr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/router_fifo_p.sv
// Parametrised per-channel packet FIFO with registered output and read-side packet length tracking.
module router_fifo_p
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int LEN_LSB    = DEF_LEN_LSB,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  pkt_done,
    output logic                  overflow,
    output logic                  pkt_err
);

    localparam int RW = DATA_WIDTH - LEN_LSB + 1;

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [RW-1:0]         r_remaining;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_pkt_done;
    logic                  r_overflow;
    logic                  r_pkt_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH:0]   w_rd_word;
    logic                  w_rd_hdr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [RW-1:0]         w_hdr_remaining;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = write_enb && !w_full;
    assign w_rd_acc = read_enb && !w_empty;

    router_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock     (clock),
        .i_we      (w_wr_acc && !soft_reset),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data ({lfd_state, data_in}),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_rd_word)
    );

    assign w_rd_hdr  = w_rd_word[DATA_WIDTH];
    assign w_rd_data = w_rd_word[DATA_WIDTH-1:0];
    // Header length plus one extra word for the trailing parity.
    assign w_hdr_remaining = RW'(hdr_len(HDR_MAX_W'(w_rd_data), LEN_LSB)) + RW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_remaining  <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_overflow   <= 1'b0;
            r_pkt_err    <= 1'b0;
        end else if (soft_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_remaining  <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_overflow   <= 1'b0;
            r_pkt_err    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            r_overflow   <= write_enb && w_full;
            r_data_valid <= w_rd_acc;
            r_pkt_done   <= 1'b0;
            r_pkt_err    <= 1'b0;

            if (w_rd_acc) begin
                r_data_out <= w_rd_data;
                if (w_rd_hdr) begin
                    // A new header always restarts tracking; an unfinished packet is flagged.
                    r_remaining <= w_hdr_remaining;
                    r_pkt_err   <= (r_remaining != '0);
                end else if (r_remaining != '0) begin
                    r_remaining <= r_remaining - RW'(1);
                    r_pkt_done  <= (r_remaining == RW'(1));
                end
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= CW'(AF_THRESH));
    assign count       = r_count;
    assign pkt_done    = r_pkt_done;
    assign overflow    = r_overflow;
    assign pkt_err     = r_pkt_err;

endmodule
